// File: rtl/bus_arbiter_if.sv
// Shared-bus arbiter signal bundle: fetch port, memory-stage port, shared bus and stalls.
// The master modport is the arbiter's view; slave is the view of the surrounding core and bus.
interface bus_arbiter_if;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_valid;
  logic [31:0] iresp_data;

  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic        dreq_write;
  logic [31:0] dreq_wdata;
  logic [3:0]  dreq_strobe;
  logic        dresp_valid;
  logic [31:0] dresp_data;

  logic        bus_req_valid;
  logic [31:0] bus_req_addr;
  logic        bus_req_write;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_strobe;
  logic        bus_req_ready;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_data;

  logic        stallF;
  logic        stallM;

  modport master (
    input  ireq_valid, ireq_addr,
    output iresp_valid, iresp_data,
    input  dreq_valid, dreq_addr, dreq_write, dreq_wdata, dreq_strobe,
    output dresp_valid, dresp_data,
    output bus_req_valid, bus_req_addr, bus_req_write, bus_req_wdata, bus_req_strobe,
    input  bus_req_ready, bus_resp_valid, bus_resp_data,
    output stallF, stallM
  );

  modport slave (
    output ireq_valid, ireq_addr,
    input  iresp_valid, iresp_data,
    output dreq_valid, dreq_addr, dreq_write, dreq_wdata, dreq_strobe,
    input  dresp_valid, dresp_data,
    input  bus_req_valid, bus_req_addr, bus_req_write, bus_req_wdata, bus_req_strobe,
    output bus_req_ready, bus_resp_valid, bus_resp_data,
    input  stallF, stallM
  );
endinterface

// File: rtl/bus_arbiter.sv
// Single-outstanding arbiter sharing one bus between fetch (I) and memory-stage (D) requests.
// D has priority, but I is forced through after STARVE_LIMIT back-to-back D grants.
module bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  bus_arbiter_if.master arb
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t      state_reg, state_next;
  owner_t      owner_reg;
  logic [3:0]  starve_cnt_reg;
  logic [31:0] addr_reg;
  logic        write_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  strobe_reg;
  logic        grant_i, grant_d, resp_fire;

  // Grants are only ever issued from IDLE, so a response cycle can never regrant.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_reg == IDLE) begin
      if (arb.dreq_valid && !(arb.ireq_valid && starve_cnt_reg == LIMIT))
        grant_d = 1'b1;
      else if (arb.ireq_valid)
        grant_i = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_i || grant_d) state_next = REQ;
      REQ:     if (arb.bus_req_ready) state_next = RESP;
      RESP:    if (arb.bus_resp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg      <= OWN_I;
      starve_cnt_reg <= 4'd0;
      addr_reg       <= 32'd0;
      write_reg      <= 1'b0;
      wdata_reg      <= 32'd0;
      strobe_reg     <= 4'd0;
    end else if (grant_d) begin
      owner_reg  <= OWN_D;
      addr_reg   <= arb.dreq_addr;
      write_reg  <= arb.dreq_write;
      wdata_reg  <= arb.dreq_wdata;
      strobe_reg <= arb.dreq_strobe;
      // Only D grants that bypass a waiting fetch count toward starvation.
      if (!arb.ireq_valid)
        starve_cnt_reg <= 4'd0;
      else if (starve_cnt_reg != LIMIT)
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end else if (grant_i) begin
      owner_reg      <= OWN_I;
      starve_cnt_reg <= 4'd0;
      addr_reg       <= arb.ireq_addr;
      write_reg      <= 1'b0;
      wdata_reg      <= 32'd0;
      strobe_reg     <= 4'd0;
    end
  end

  // Reset masks every pulse combinationally so a reset cycle never leaks a response.
  always_comb begin
    resp_fire          = (state_reg == RESP) && arb.bus_resp_valid && !reset;
    arb.bus_req_valid  = (state_reg == REQ) && !reset;
    arb.bus_req_addr   = addr_reg;
    arb.bus_req_write  = write_reg;
    arb.bus_req_wdata  = wdata_reg;
    arb.bus_req_strobe = strobe_reg;
    arb.iresp_valid    = resp_fire && (owner_reg == OWN_I);
    arb.dresp_valid    = resp_fire && (owner_reg == OWN_D);
    arb.iresp_data     = arb.iresp_valid ? arb.bus_resp_data : 32'd0;
    arb.dresp_data     = arb.dresp_valid ? arb.bus_resp_data : 32'd0;
    arb.stallF         = arb.ireq_valid && !arb.iresp_valid;
    arb.stallM         = arb.dreq_valid && !arb.dresp_valid;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: IDLE vector table, directed latency/priority/starvation/
// backpressure/reset sequences, and randomized traffic against a transaction-level model.
module tb_bus_arbiter;
  localparam int LIMIT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if bif();

  bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bif)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench-side requesters, bus-slave knobs and the transaction-level model.
  bit          i_pend, d_pend, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_strobe;
  int          i_budget, d_budget, ready_wait;
  int unsigned i_pct, d_pct, ready_pct, resp_pct, noise_pct;
  bit          fixed_fields;
  bit          busy, accepted, own_d;
  int          d_run, req_wait_cnt, req_cycles;
  logic [31:0] ex_addr, ex_wdata;
  logic        ex_write;
  logic [3:0]  ex_strobe;
  byte         order[$];

  task automatic drive_zero();
    bif.ireq_valid = 1'b0;     bif.ireq_addr = 32'd0;
    bif.dreq_valid = 1'b0;     bif.dreq_addr = 32'd0;
    bif.dreq_write = 1'b0;     bif.dreq_wdata = 32'd0;
    bif.dreq_strobe = 4'd0;    bif.bus_req_ready = 1'b0;
    bif.bus_resp_valid = 1'b0; bif.bus_resp_data = 32'd0;
  endtask

  task automatic do_reset();
    drive_zero();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    i_pend = 0; d_pend = 0; busy = 0; accepted = 0; own_d = 0;
    d_run = 0; req_wait_cnt = 0; req_cycles = 0;
    order.delete();
  endtask

  task automatic run_cycle();
    bit rdy, rv, in_resp, exp_req, exp_i, exp_d;
    logic [31:0] rdata;
    if (!i_pend && i_budget > 0 && $urandom_range(99) < i_pct) begin
      i_pend = 1; i_budget--;
      i_addr = fixed_fields ? 32'h1000 : ($urandom & 32'hFFFF_FFFC);
    end
    if (!d_pend && d_budget > 0 && $urandom_range(99) < d_pct) begin
      d_pend = 1; d_budget--;
      d_addr   = fixed_fields ? 32'h2000 : $urandom;
      d_wr     = fixed_fields ? 1'b1 : 1'($urandom_range(1));
      d_wdata  = fixed_fields ? 32'h1234_5678 : $urandom;
      d_strobe = fixed_fields ? 4'hF : 4'($urandom_range(15));
    end
    rdy     = (ready_wait >= 0) ? (req_wait_cnt >= ready_wait) : ($urandom_range(99) < ready_pct);
    in_resp = busy && accepted;
    rv      = in_resp ? ($urandom_range(99) < resp_pct) : ($urandom_range(99) < noise_pct);
    rdata   = $urandom;
    bif.ireq_valid = i_pend;  bif.ireq_addr = i_addr;
    bif.dreq_valid = d_pend;  bif.dreq_addr = d_addr;  bif.dreq_write = d_wr;
    bif.dreq_wdata = d_wdata; bif.dreq_strobe = d_strobe;
    bif.bus_req_ready = rdy;  bif.bus_resp_valid = rv;  bif.bus_resp_data = rdata;
    #1;
    exp_req = busy && !accepted;
    exp_i   = in_resp && rv && !own_d;
    exp_d   = in_resp && rv && own_d;
    chk1("bus_req_valid", bif.bus_req_valid, exp_req);
    if (exp_req) begin
      chk32("bus_req_addr", bif.bus_req_addr, ex_addr);
      chk1("bus_req_write", bif.bus_req_write, ex_write);
      chk32("bus_req_wdata", bif.bus_req_wdata, ex_wdata);
      chk32("bus_req_strobe", 32'(bif.bus_req_strobe), 32'(ex_strobe));
    end
    chk1("iresp_valid", bif.iresp_valid, exp_i);
    chk1("dresp_valid", bif.dresp_valid, exp_d);
    if (exp_i) chk32("iresp_data", bif.iresp_data, rdata);
    if (exp_d) chk32("dresp_data", bif.dresp_data, rdata);
    chk1("stallF", bif.stallF, i_pend && !exp_i);
    chk1("stallM", bif.stallM, d_pend && !exp_d);
    if (bif.iresp_valid) order.push_back("I");
    if (bif.dresp_valid) order.push_back("D");
    if (bif.bus_req_valid) req_cycles++;
    // Transaction-level model: one bus transaction at a time, arbitration only when free.
    if (!busy) begin
      if (d_pend && !(i_pend && d_run == LIMIT)) begin
        own_d = 1; ex_addr = d_addr; ex_write = d_wr; ex_wdata = d_wdata; ex_strobe = d_strobe;
        d_run = i_pend ? ((d_run < LIMIT) ? d_run + 1 : LIMIT) : 0;
        busy = 1; accepted = 0; req_wait_cnt = 0;
      end else if (i_pend) begin
        own_d = 0; ex_addr = i_addr; ex_write = 1'b0; ex_wdata = 32'd0; ex_strobe = 4'd0;
        d_run = 0;
        busy = 1; accepted = 0; req_wait_cnt = 0;
      end
    end else if (!accepted) begin
      if (rdy) accepted = 1;
      else req_wait_cnt++;
    end else if (rv) begin
      busy = 0;
      if (own_d) d_pend = 0;
      else i_pend = 0;
    end
    tick();
  endtask

  task automatic setup_knobs(input int ib, input int db, input int rw, input int unsigned ip,
                             input int unsigned dp, input int unsigned rp, input int unsigned sp,
                             input int unsigned np, input bit fx);
    i_budget = ib; d_budget = db; ready_wait = rw; i_pct = ip; d_pct = dp;
    ready_pct = rp; resp_pct = sp; noise_pct = np; fixed_fields = fx;
  endtask

  function automatic byte order_at(input int k);
    return (k < order.size()) ? order[k] : 8'h3F;
  endfunction

  typedef struct {
    logic        iv, dv, dw, br;
    logic        exp_sf, exp_sm, exp_rv;
    logic [31:0] exp_addr;
    logic        exp_w;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // {iv, dv, dw, resp_in_idle, stallF, stallM, next bus_req_valid, next addr, next write}
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2000, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2000, 1'b0};

    drive_zero();
    do_reset();
    chk1("reset_bus_req_valid", bif.bus_req_valid, 1'b0);
    chk32("reset_bus_req_addr", bif.bus_req_addr, 32'h0);
    chk1("reset_iresp_valid", bif.iresp_valid, 1'b0);
    chk1("reset_dresp_valid", bif.dresp_valid, 1'b0);

    for (int k = 0; k < 6; k++) begin
      do_reset();
      bif.ireq_valid = vecs[k].iv;  bif.ireq_addr = 32'h1000;
      bif.dreq_valid = vecs[k].dv;  bif.dreq_addr = 32'h2000;  bif.dreq_write = vecs[k].dw;
      bif.dreq_wdata = 32'h1234_5678; bif.dreq_strobe = 4'hF;
      bif.bus_resp_valid = vecs[k].br; bif.bus_resp_data = 32'hBAD0_BAD0;
      #1;
      chk1($sformatf("vec%0d_stallF", k), bif.stallF, vecs[k].exp_sf);
      chk1($sformatf("vec%0d_stallM", k), bif.stallM, vecs[k].exp_sm);
      chk1($sformatf("vec%0d_idle_iresp", k), bif.iresp_valid, 1'b0);
      chk1($sformatf("vec%0d_idle_dresp", k), bif.dresp_valid, 1'b0);
      chk1($sformatf("vec%0d_idle_req", k), bif.bus_req_valid, 1'b0);
      tick();
      #1;
      chk1($sformatf("vec%0d_req_valid", k), bif.bus_req_valid, vecs[k].exp_rv);
      chk32($sformatf("vec%0d_req_addr", k), bif.bus_req_addr, vecs[k].exp_addr);
      chk1($sformatf("vec%0d_req_write", k), bif.bus_req_write, vecs[k].exp_w);
      chk1($sformatf("vec%0d_req_iresp", k), bif.iresp_valid, 1'b0);
      chk1($sformatf("vec%0d_req_dresp", k), bif.dresp_valid, 1'b0);
    end

    // Fetch only, zero-wait bus: request at cycle 0, bus at 1, response at 2.
    do_reset();
    bif.ireq_valid = 1'b1; bif.ireq_addr = 32'h1000; bif.bus_req_ready = 1'b1;
    #1;
    chk1("only_i_c0_stallF", bif.stallF, 1'b1);
    chk1("only_i_c0_req", bif.bus_req_valid, 1'b0);
    tick(); #1;
    chk1("only_i_c1_req", bif.bus_req_valid, 1'b1);
    chk32("only_i_c1_addr", bif.bus_req_addr, 32'h1000);
    chk1("only_i_c1_write", bif.bus_req_write, 1'b0);
    chk1("only_i_c1_stallF", bif.stallF, 1'b1);
    tick();
    bif.bus_resp_valid = 1'b1; bif.bus_resp_data = 32'hDEAD_BEEF;
    #1;
    chk1("only_i_c2_iresp", bif.iresp_valid, 1'b1);
    chk32("only_i_c2_data", bif.iresp_data, 32'hDEAD_BEEF);
    chk1("only_i_c2_stallF", bif.stallF, 1'b0);
    chk1("only_i_c2_dresp", bif.dresp_valid, 1'b0);
    tick();
    bif.ireq_valid = 1'b0; bif.bus_resp_valid = 1'b0;
    #1;
    chk1("only_i_c3_iresp", bif.iresp_valid, 1'b0);
    chk1("only_i_c3_req", bif.bus_req_valid, 1'b0);

    // Both pending: D store goes first, I follows at the next IDLE.
    do_reset();
    setup_knobs(1, 1, -1, 100, 100, 100, 100, 0, 1'b1);
    for (int c = 0; c < 8; c++) run_cycle();
    chk32("both_first", 32'(order_at(0)), 32'("D"));
    chk32("both_second", 32'(order_at(1)), 32'("I"));

    // Starvation with limit 2: D, D, I, D.
    do_reset();
    setup_knobs(1, 10, -1, 100, 100, 100, 100, 0, 1'b1);
    for (int c = 0; c < 14; c++) run_cycle();
    chk32("starve_g0", 32'(order_at(0)), 32'("D"));
    chk32("starve_g1", 32'(order_at(1)), 32'("D"));
    chk32("starve_g2", 32'(order_at(2)), 32'("I"));
    chk32("starve_g3", 32'(order_at(3)), 32'("D"));

    // Backpressure: ready low for 3 REQ cycles gives 4 cycles of held request.
    do_reset();
    setup_knobs(1, 0, 3, 100, 0, 0, 100, 0, 1'b1);
    for (int c = 0; c < 9; c++) run_cycle();
    chk32("backpressure_req_cycles", 32'(req_cycles), 32'd4);
    chk32("backpressure_resp", 32'(order_at(0)), 32'("I"));

    // Reset while in RESP, then a stale bus response the cycle after.
    do_reset();
    bif.ireq_valid = 1'b1; bif.ireq_addr = 32'h1000; bif.bus_req_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bif.ireq_valid = 1'b0; bif.bus_resp_valid = 1'b1; bif.bus_resp_data = 32'h5555_AAAA;
    #1;
    chk1("rst_resp_iresp", bif.iresp_valid, 1'b0);
    chk1("rst_resp_dresp", bif.dresp_valid, 1'b0);
    chk1("rst_resp_req", bif.bus_req_valid, 1'b0);
    tick();
    bif.bus_resp_valid = 1'b0;
    #1;
    chk1("rst_resp_idle_req", bif.bus_req_valid, 1'b0);
    chk32("rst_resp_addr", bif.bus_req_addr, 32'h0);

    // Randomized traffic with bus backpressure, response delays and spurious responses.
    do_reset();
    setup_knobs(100000, 100000, -1, 40, 50, 60, 50, 20, 1'b0);
    for (int c = 0; c < 3000; c++) run_cycle();
    chk1("random_progress", order.size() > 100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the maximum consecutive data grants while a fetch is pending (range 1..15).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-004 ireq_valid  in  1  SHALL mean fetch request pending; held stable until iresp_valid.
REQ-005 ireq_addr  in  32  SHALL be the fetch byte address.
REQ-006 iresp_valid  out  1  SHALL be a one-cycle pulse returning fetch data.
REQ-007 iresp_data  out  32  SHALL be the fetch data, valid only with iresp_valid.
REQ-008 dreq_valid  in  1  SHALL mean memory-stage request pending; held stable until dresp_valid.
REQ-009 dreq_addr  in  32  SHALL be the memory-stage byte address.
REQ-010 dreq_write  in  1  SHALL be 1 for store, 0 for load.
REQ-011 dreq_wdata  in  32  SHALL be the store data.
REQ-012 dreq_strobe  in  4  SHALL be the byte-enable mask for stores.
REQ-013 dresp_valid  out  1  SHALL be a one-cycle pulse completing the memory-stage request.
REQ-014 dresp_data  out  32  SHALL be the load data, valid only with dresp_valid.
REQ-015 bus_req_valid  out  1  SHALL mean the shared bus address phase is presented.
REQ-016 bus_req_addr/bus_req_write/bus_req_wdata/bus_req_strobe  out  32/1/32/4  SHALL be the latched request fields.
REQ-017 bus_req_ready  in  1  SHALL mean the bus accepts the address phase this cycle.
REQ-018 bus_resp_valid  in  1  SHALL mean bus response data is valid this cycle.
REQ-019 bus_resp_data  in  32  SHALL be the bus response data.
REQ-020 stallF, stallM  out  1 each  SHALL request fetch and memory-stage stalls.

Function
REQ-021 The FSM SHALL have states IDLE, REQ, RESP, plus an owner register (I or D).
REQ-022 In IDLE with any request pending, the arbiter SHALL latch the winner's fields and owner, then enter REQ next cycle; with none pending it stays in IDLE.
REQ-023 Arbitration priority SHALL be: D over I, except I wins when both are pending and starve_cnt == STARVE_LIMIT.
REQ-024 starve_cnt SHALL increment on a D grant while ireq_valid=1, clear on any I grant or on a D grant with ireq_valid=0, and saturate at STARVE_LIMIT.
REQ-025 For an I grant, latched fields SHALL be write=0, wdata=0, strobe=0.
REQ-026 bus_req_valid SHALL be 1 exactly while in REQ, with all bus_req_* fields stable until accepted.
REQ-027 In REQ, bus_req_valid && bus_req_ready SHALL move the FSM to RESP next cycle; otherwise it stays in REQ.
REQ-028 In RESP, bus_resp_valid SHALL pulse the owner's resp_valid in the same cycle, pass bus_resp_data through to its resp_data, and return the FSM to IDLE.
REQ-029 Minimum latency SHALL be: request sampled in IDLE at cycle 0, bus_req_valid at 1, response earliest at cycle 2 (zero-wait bus).
REQ-030 bus_resp_valid SHALL be ignored in IDLE and REQ.
REQ-031 A request SHALL NOT be granted in the cycle its response is returned; regrant is evaluated only in IDLE.
REQ-032 stallF SHALL equal ireq_valid && !iresp_valid; stallM SHALL equal dreq_valid && !dresp_valid (combinational).
REQ-033 Outstanding bus transactions SHALL be limited to one.

Reset
REQ-034 Reset SHALL force IDLE, owner=I, starve_cnt=0, all latched bus fields=0, and bus_req_valid/iresp_valid/dresp_valid=0, regardless of the current state.
REQ-035 A response arriving in the cycle after a reset that was asserted mid-transaction SHALL be ignored.

Verification
REQ-036 Only I: ireq_addr=0x1000, ready=1, resp at cycle 2 with 0xDEADBEEF -> bus_req_valid at cycle 1 with addr 0x1000, write=0; iresp_valid=1 with data 0xDEADBEEF at cycle 2; stallF=1 at cycles 0-1.
REQ-037 Both pending: I=0x1000, D store 0x2000/0x12345678/strobe 0xF -> D granted first (bus write=1, addr 0x2000); I granted at the next IDLE; dresp_valid precedes iresp_valid.
REQ-038 Starvation, STARVE_LIMIT=2: I held and D continuously re-requesting -> grant order D, D, I, D.
REQ-039 Backpressure: bus_req_ready=0 for 3 cycles -> bus_req_* held constant for 4 cycles of REQ; RESP is entered only after ready=1.
REQ-040 Reset in RESP, then bus_resp_valid=1 in the next cycle -> no resp_valid pulse; FSM in IDLE; bus_req_valid=0.
REQ-041 bus_resp_valid=1 while in IDLE -> no output change.
